// File: rtl/cv32e40x_pkg.sv
// Shared types for the XIF AES32 result path.
//  xif_aes_res_entry_t : one buffered FU result {id, rd, data} at the
//                        default XIF widths (4-bit ID, 32-bit data)
//  res_head_e          : disposition of the result-queue head entry
package cv32e40x_pkg;

   localparam int XIF_AES_ID_WIDTH  = 4;
   localparam int XIF_AES_RFW_WIDTH = 32;

   typedef struct packed {
      logic [XIF_AES_ID_WIDTH-1:0]  id;
      logic [4:0]                   rd;
      logic [XIF_AES_RFW_WIDTH-1:0] data;
   } xif_aes_res_entry_t;

   typedef enum logic [1:0] {
      RES_WAIT,
      RES_PRESENT,
      RES_DROP
   } res_head_e;

endpackage

// File: rtl/cv32e40x_xif_commit_tracker.sv
// Per-instruction-ID commit/kill table for offloaded AES instructions.
//  clk_i, rst_n           : clock, async active-low reset
//  set_valid/id/kill      : commit strobe; marks ID seen with its kill flag
//  clr_valid/id           : retire strobe; clears the slot of a popped head
//  lookup_id              : ID whose registered state is reported
//  seen, kill             : registered table bits for lookup_id
module cv32e40x_xif_commit_tracker #(
   parameter int X_ID_WIDTH = 4
) (
   input  logic                  clk_i,
   input  logic                  rst_n,
   input  logic                  set_valid,
   input  logic [X_ID_WIDTH-1:0] set_id,
   input  logic                  set_kill,
   input  logic                  clr_valid,
   input  logic [X_ID_WIDTH-1:0] clr_id,
   input  logic [X_ID_WIDTH-1:0] lookup_id,
   output logic                  seen,
   output logic                  kill
);

   localparam int SLOTS = 2 ** X_ID_WIDTH;

   logic [SLOTS-1:0] seen_q;
   logic [SLOTS-1:0] kill_q;

   // Clear is applied before set so a commit arriving in the same cycle the
   // ID retires (an ID being reused) is not lost.
   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         seen_q <= '0;
         kill_q <= '0;
      end else begin
         if (clr_valid) begin
            seen_q[clr_id] <= 1'b0;
            kill_q[clr_id] <= 1'b0;
         end
         if (set_valid) begin
            seen_q[set_id] <= 1'b1;
            kill_q[set_id] <= set_kill;
         end
      end
   end

   assign seen = seen_q[lookup_id];
   assign kill = kill_q[lookup_id];

endmodule

// File: rtl/cv32e40x_xif_aes_result_queue.sv
// In-order result queue between the AES32 coprocessor FU and the XIF result
// channel. Results are held until their ID is committed; killed results are
// dropped without ever being presented.
//  clk_i, rst_n                  : clock, async active-low reset
//  fu_valid_i/ready_o/id/rd/data : FU result push side
//  commit_valid_i/id_i/kill_i    : XIF commit channel
//  result_valid_o/ready_i/id/rd/data/we : XIF result channel
//  count_o                       : occupied entries
module cv32e40x_xif_aes_result_queue
   import cv32e40x_pkg::*;
#(
   parameter int DEPTH       = 2,
   parameter int X_ID_WIDTH  = 4,
   parameter int X_RFW_WIDTH = 32
) (
   input  logic                       clk_i,
   input  logic                       rst_n,
   input  logic                       fu_valid_i,
   output logic                       fu_ready_o,
   input  logic [X_ID_WIDTH-1:0]      fu_id_i,
   input  logic [4:0]                 fu_rd_i,
   input  logic [X_RFW_WIDTH-1:0]     fu_data_i,
   input  logic                       commit_valid_i,
   input  logic [X_ID_WIDTH-1:0]      commit_id_i,
   input  logic                       commit_kill_i,
   output logic                       result_valid_o,
   input  logic                       result_ready_i,
   output logic [X_ID_WIDTH-1:0]      result_id_o,
   output logic [4:0]                 result_rd_o,
   output logic [X_RFW_WIDTH-1:0]     result_data_o,
   output logic                       result_we_o,
   output logic [$clog2(DEPTH):0]     count_o
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = 1;
   localparam logic [AW:0] CNT_MAX = DEPTH[AW:0];

   // Same layout as xif_aes_res_entry_t, sized by this instance's parameters.
   typedef struct packed {
      logic [X_ID_WIDTH-1:0]  id;
      logic [4:0]             rd;
      logic [X_RFW_WIDTH-1:0] data;
   } entry_t;

   entry_t      mem [DEPTH];
   logic [AW:0] wr_ptr, rd_ptr, count;
   entry_t      head;
   res_head_e   head_state;
   logic        full, empty, push, pop;
   logic        head_seen, head_kill;

   assign full       = (count == CNT_MAX);
   assign empty      = (count == '0);
   assign fu_ready_o = !full;
   assign push       = fu_valid_i && !full;
   assign head       = mem[rd_ptr[AW-1:0]];
   assign count_o    = count;

   cv32e40x_xif_commit_tracker #(
      .X_ID_WIDTH (X_ID_WIDTH)
   ) u_commit_tracker (
      .clk_i     (clk_i),
      .rst_n     (rst_n),
      .set_valid (commit_valid_i),
      .set_id    (commit_id_i),
      .set_kill  (commit_kill_i),
      .clr_valid (pop),
      .clr_id    (head.id),
      .lookup_id (head.id),
      .seen      (head_seen),
      .kill      (head_kill)
   );

   // Head disposition uses only registered table state, so a commit shows
   // up at the head one cycle after its strobe.
   always_comb begin
      head_state = RES_WAIT;
      if (!empty && head_seen) begin
         head_state = head_kill ? RES_DROP : RES_PRESENT;
      end
   end

   assign pop = (head_state == RES_DROP) ||
                ((head_state == RES_PRESENT) && result_ready_i);

   always_comb begin
      result_valid_o = 1'b0;
      result_id_o    = '0;
      result_rd_o    = '0;
      result_data_o  = '0;
      if (head_state == RES_PRESENT) begin
         result_valid_o = 1'b1;
         result_id_o    = head.id;
         result_rd_o    = head.rd;
         result_data_o  = head.data;
      end
   end

   assign result_we_o = result_valid_o;

   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
         if (push && !pop)      count <= count + PTR_ONE;
         else if (!push && pop) count <= count - PTR_ONE;
      end
   end

   // Storage needs no reset: an entry is only observed between push and pop.
   always_ff @(posedge clk_i) begin
      if (push) mem[wr_ptr[AW-1:0]] <= '{id: fu_id_i, rd: fu_rd_i, data: fu_data_i};
   end

   a_fu_overflow : assert property (@(posedge clk_i) disable iff (!rst_n)
      fu_valid_i |-> fu_ready_o);

   a_result_stable : assert property (@(posedge clk_i) disable iff (!rst_n)
      (result_valid_o && !result_ready_i) |=>
      (result_valid_o && $stable(result_id_o) && $stable(result_rd_o) && $stable(result_data_o)));

endmodule

// File: tb/tb_cv32e40x_xif_aes_result_queue.sv
module tb_cv32e40x_xif_aes_result_queue;

   logic        clk_i = 1'b0;
   logic        rst_n = 1'b0;
   logic        fu_valid_i = 1'b0;
   logic        fu_ready_o;
   logic [3:0]  fu_id_i = '0;
   logic [4:0]  fu_rd_i = '0;
   logic [31:0] fu_data_i = '0;
   logic        commit_valid_i = 1'b0;
   logic [3:0]  commit_id_i = '0;
   logic        commit_kill_i = 1'b0;
   logic        result_valid_o;
   logic        result_ready_i = 1'b1;
   logic [3:0]  result_id_o;
   logic [4:0]  result_rd_o;
   logic [31:0] result_data_o;
   logic        result_we_o;
   logic [1:0]  count_o;

   int checks = 0;
   int errors = 0;
   logic [40:0] sb [$];   // {id, rd, data}

   cv32e40x_xif_aes_result_queue #(.DEPTH(2), .X_ID_WIDTH(4), .X_RFW_WIDTH(32)) dut (
      .clk_i          (clk_i),
      .rst_n          (rst_n),
      .fu_valid_i     (fu_valid_i),
      .fu_ready_o     (fu_ready_o),
      .fu_id_i        (fu_id_i),
      .fu_rd_i        (fu_rd_i),
      .fu_data_i      (fu_data_i),
      .commit_valid_i (commit_valid_i),
      .commit_id_i    (commit_id_i),
      .commit_kill_i  (commit_kill_i),
      .result_valid_o (result_valid_o),
      .result_ready_i (result_ready_i),
      .result_id_o    (result_id_o),
      .result_rd_o    (result_rd_o),
      .result_data_o  (result_data_o),
      .result_we_o    (result_we_o),
      .count_o        (count_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got=%0h want=%0h @%0t", tag, obs, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic fu_push(input logic [3:0] id, input logic [4:0] rd, input logic [31:0] data,
                          input bit expect_out);
      fu_valid_i = 1'b1;
      fu_id_i    = id;
      fu_rd_i    = rd;
      fu_data_i  = data;
      if (expect_out) sb.push_back({id, rd, data});
   endtask

   task automatic commit(input logic [3:0] id, input logic kill);
      commit_valid_i = 1'b1;
      commit_id_i    = id;
      commit_kill_i  = kill;
   endtask

   // Scoreboard: every accepted result must be the oldest expected one.
   always @(negedge clk_i) begin
      if (rst_n && result_valid_o && result_ready_i) begin
         chk("sb_nonempty", 64'(sb.size() != 0), 64'd1);
         if (sb.size() != 0) begin
            logic [40:0] e;
            e = sb.pop_front();
            chk("sb_id",   64'(result_id_o),   64'(e[40:37]));
            chk("sb_rd",   64'(result_rd_o),   64'(e[36:32]));
            chk("sb_data", 64'(result_data_o), 64'(e[31:0]));
            chk("sb_we",   64'(result_we_o),   64'd1);
         end
      end
   end

   initial begin
      // reset state
      @(negedge clk_i);
      chk("rst_valid", 64'(result_valid_o), 0);
      chk("rst_we",    64'(result_we_o), 0);
      chk("rst_ready", 64'(fu_ready_o), 1);
      chk("rst_count", 64'(count_o), 0);
      chk("rst_id",    64'(result_id_o), 0);
      chk("rst_data",  64'(result_data_o), 0);
      rst_n = 1'b1;

      // commit first, then push: valid the cycle after push
      tick(); commit(4'd3, 1'b0);
      tick(); commit_valid_i = 1'b0; fu_push(4'd3, 5'd5, 32'hDEADBEEF, 1'b1);
      @(negedge clk_i); chk("t1_count0", 64'(count_o), 0);
      chk("t1_valid0", 64'(result_valid_o), 0);
      tick(); fu_valid_i = 1'b0;
      @(negedge clk_i); chk("t1_valid", 64'(result_valid_o), 1);
      chk("t1_count1", 64'(count_o), 1);
      chk("t1_id", 64'(result_id_o), 3);
      tick();
      @(negedge clk_i); chk("t1_count_end", 64'(count_o), 0);

      // commit held off 4 cycles
      tick(); fu_push(4'd1, 5'd7, 32'h1111_0001, 1'b1);
      tick(); fu_valid_i = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk_i); chk("t2_wait", 64'(result_valid_o), 0);
         tick();
      end
      commit(4'd1, 1'b0);
      @(negedge clk_i); chk("t2_commit_cyc", 64'(result_valid_o), 0);
      tick(); commit_valid_i = 1'b0;
      @(negedge clk_i); chk("t2_valid", 64'(result_valid_o), 1);
      tick();
      @(negedge clk_i); chk("t2_count_end", 64'(count_o), 0);

      // kill -> dropped silently
      tick(); fu_push(4'd2, 5'd3, 32'h2222_0002, 1'b0);
      tick(); fu_valid_i = 1'b0; commit(4'd2, 1'b1);
      @(negedge clk_i); chk("t3_count1", 64'(count_o), 1);
      chk("t3_valid_a", 64'(result_valid_o), 0);
      tick(); commit_valid_i = 1'b0;
      @(negedge clk_i); chk("t3_valid_b", 64'(result_valid_o), 0);
      tick();
      @(negedge clk_i); chk("t3_count_end", 64'(count_o), 0);
      chk("t3_valid_c", 64'(result_valid_o), 0);

      // fill, then commit out of order; in-order emission
      tick(); fu_push(4'd4, 5'd4, 32'hA4A4_0004, 1'b1);
      tick(); fu_push(4'd5, 5'd9, 32'hA5A5_0005, 1'b1);
      tick(); fu_valid_i = 1'b0;
      @(negedge clk_i); chk("t4_full_ready", 64'(fu_ready_o), 0);
      chk("t4_full_count", 64'(count_o), 2);
      tick(); commit(4'd5, 1'b0);
      @(negedge clk_i); chk("t4_block_a", 64'(result_valid_o), 0);
      tick(); commit(4'd4, 1'b0);
      @(negedge clk_i); chk("t4_block_b", 64'(result_valid_o), 0);
      tick(); commit_valid_i = 1'b0;
      @(negedge clk_i); chk("t4_first_id", 64'(result_id_o), 4);
      tick();
      @(negedge clk_i); chk("t4_second_id", 64'(result_id_o), 5);
      chk("t4_second_valid", 64'(result_valid_o), 1);
      tick();
      @(negedge clk_i); chk("t4_count_end", 64'(count_o), 0);

      // back-pressure: hold stable, concurrent push accepted
      tick(); commit(4'd6, 1'b0);
      tick(); commit_valid_i = 1'b0; fu_push(4'd6, 5'd6, 32'hB6B6_0006, 1'b1);
      tick(); fu_valid_i = 1'b0; result_ready_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk_i);
         chk("t5_hold_valid", 64'(result_valid_o), 1);
         chk("t5_hold_id",    64'(result_id_o), 6);
         chk("t5_hold_data",  64'(result_data_o), 64'hB6B6_0006);
         tick();
         if (i == 0) fu_push(4'd7, 5'd8, 32'hB7B7_0007, 1'b1);
         else        fu_valid_i = 1'b0;
      end
      @(negedge clk_i); chk("t5_count2", 64'(count_o), 2);
      chk("t5_still_valid", 64'(result_valid_o), 1);

      // reset with two entries and a presented result
      #1 rst_n = 1'b0;
      sb.delete();
      #1;
      chk("t6_valid", 64'(result_valid_o), 0);
      chk("t6_we",    64'(result_we_o), 0);
      chk("t6_count", 64'(count_o), 0);
      chk("t6_id",    64'(result_id_o), 0);
      chk("t6_data",  64'(result_data_o), 0);
      tick(); rst_n = 1'b1; result_ready_i = 1'b1;
      @(negedge clk_i); chk("t6_ready", 64'(fu_ready_o), 1);
      tick(); commit(4'd7, 1'b0);
      tick(); commit_valid_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk_i); chk("t6_no_result", 64'(result_valid_o), 0);
         tick();
      end

      // simultaneous push and pop keeps count
      commit(4'd8, 1'b0);
      tick(); commit(4'd9, 1'b0);
      tick(); commit_valid_i = 1'b0; fu_push(4'd8, 5'd1, 32'hC8C8_0008, 1'b1);
      tick(); fu_push(4'd9, 5'd2, 32'hC9C9_0009, 1'b1);
      @(negedge clk_i); chk("t7_count_a", 64'(count_o), 1);
      chk("t7_head8", 64'(result_id_o), 8);
      tick(); fu_valid_i = 1'b0;
      @(negedge clk_i); chk("t7_count_b", 64'(count_o), 1);
      chk("t7_head9", 64'(result_id_o), 9);
      tick();
      @(negedge clk_i); chk("t7_count_end", 64'(count_o), 0);

      tick(); tick();
      chk("sb_drained", 64'(sb.size()), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
